spi_omega_bank: RTL and testbench

//  Multi-channel SPI tuning-word receiver, successor to the single 40-bit omega receiver.

---
 rtl/spi_bank_pkg.sv | 29 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_omega_bank.sv | 182 ++++++++++++++++++
 tb/tb_spi_omega_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bank_pkg.sv
// rtl/spi_bank_pkg.sv - shared types and frame-geometry helpers for the SPI omega bank
//
// Purpose: frame width, commit address and bit-counter width helpers, plus the
//          receive state enum used by spi_omega_bank.
package spi_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    function automatic int frame_w(input int addr_w, input int word_w);
        return addr_w + word_w;
    endfunction

    // The all-ones address is reserved for the broadcast commit frame.
    function automatic int commit_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // Counter must hold 0..FRAME_W+1; FRAME_W+1 marks an overrun.
    function automatic int cnt_width(input int fw);
        return $clog2(fw + 2);
    endfunction

    localparam int DEF_FRAME_W = frame_w(4, 40);
    localparam int DEF_CNT_W   = cnt_width(DEF_FRAME_W);

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detection
//
// Purpose: bring one asynchronous pin into clk and flag its edges.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   din          asynchronous input pin
//   level        synchronised level (last stage)
//   rise, fall   1-cycle pulses, last stage compared against one extra flop
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to 0 so a select pin already low at reset release produces no
    // fall edge: the receiver then waits for a genuine new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_omega_bank.sv
// rtl/spi_omega_bank.sv - multi-channel SPI tuning-word receiver with shadow/commit
//
// Purpose: receive {address, word} SPI mode-0 frames in the clk domain, write
//          per-channel shadow registers and move them to the active omega
//          outputs immediately (AUTO_COMMIT) or on a broadcast commit frame.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   sck,mosi,ssel SPI pins (mode 0, MSB first, select active low)
//   omega         active words, channel k at [k*WORD_W +: WORD_W]
//   omega_update  1-cycle pulse when any active word is written
//   frame_err     1-cycle pulse when a frame is rejected
module spi_omega_bank
    import spi_bank_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WORD_W      = 40,
    parameter int ADDR_W      = 4,
    parameter int AUTO_COMMIT = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sck,
    input  logic                   mosi,
    input  logic                   ssel,
    output logic [N_CH*WORD_W-1:0] omega,
    output logic                   omega_update,
    output logic                   frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, WORD_W);
    localparam int CNT_W   = cnt_width(FRAME_W);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] COMMIT_A = ADDR_W'(commit_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] NCH_A    = ADDR_W'(N_CH);
    localparam logic              AUTO     = (AUTO_COMMIT != 0);

    if (N_CH < 1 || N_CH >= (1 << ADDR_W)) begin : g_bad_nch
        $error("spi_omega_bank: N_CH must be in 1..2**ADDR_W-1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_omega_bank: SYNC_STAGES must be >= 2");
    end

    logic sck_rise, ssel_rise, ssel_fall, mosi_lvl;
    logic sck_unused_lvl, sck_unused_fall, ssel_unused_lvl;
    logic mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck),
        .level(sck_unused_lvl), .rise(sck_rise), .fall(sck_unused_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ssel (
        .clk(clk), .rst_n(rst_n), .din(ssel),
        .level(ssel_unused_lvl), .rise(ssel_rise), .fall(ssel_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_lvl), .rise(mosi_unused_rise), .fall(mosi_unused_fall)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               eval_q, eval_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;
    logic [WORD_W-1:0]  shadow_q [N_CH];
    logic [WORD_W-1:0]  active_q [N_CH];

    logic [ADDR_W-1:0]  frm_addr;
    logic [WORD_W-1:0]  frm_data;
    logic [N_CH-1:0]    wr_vec;
    logic               commit_all;

    assign frm_addr = shift_q[FRAME_W-1 -: ADDR_W];
    assign frm_data = shift_q[WORD_W-1:0];

    // Receive FSM. A sck edge in the same cycle as the closing ssel edge is
    // still shifted in, so the frame is judged on its complete bit count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        eval_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (sck_rise) begin
                    shift_d = {shift_q[FRAME_W-2:0], mosi_lvl};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (ssel_rise) begin
                    state_d = IDLE;
                    eval_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode runs one cycle after the closing edge on the settled counter and
    // shift register; a new frame starting in that cycle clears them only at
    // the end of it, so the previous result is unaffected.
    always_comb begin
        wr_vec     = '0;
        commit_all = 1'b0;
        upd_d      = 1'b0;
        err_d      = 1'b0;
        if (eval_q && cnt_q != '0) begin
            if (cnt_q != CNT_FULL) begin
                err_d = 1'b1;
            end else if (frm_addr == COMMIT_A) begin
                commit_all = 1'b1;
                upd_d      = 1'b1;
            end else if (frm_addr < NCH_A) begin
                for (int k = 0; k < N_CH; k++) begin
                    wr_vec[k] = (frm_addr == ADDR_W'(k));
                end
                upd_d = AUTO;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            eval_q  <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            eval_q  <= eval_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr_vec[k]) begin
                    shadow_q[k] <= frm_data;
                end
                if (commit_all) begin
                    active_q[k] <= shadow_q[k];
                end else if (wr_vec[k] && AUTO) begin
                    active_q[k] <= frm_data;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_omega
        assign omega[g*WORD_W +: WORD_W] = active_q[g];
    end

    assign omega_update = upd_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_omega_bank.sv
// tb/tb_spi_omega_bank.sv - scoreboard bench for spi_omega_bank (manual and auto commit)
module tb_spi_omega_bank;

    localparam int NCH = 4;
    localparam int WW  = 40;
    localparam int OW  = NCH * WW;
    localparam int LAT = 4;

    typedef struct {
        bit             is_err;
        logic [OW-1:0]  omega;
        int             rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic ssel = 1'b1;

    logic [OW-1:0] om  [2];
    logic          upd [2];
    logic          err [2];

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int n_pulse [2] = '{0, 0};

    exp_t          sbq [2][$];
    logic [WW-1:0] sh  [2][NCH];
    logic [WW-1:0] act [2][NCH];
    logic [OW-1:0] prev_om [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_omega_bank #(.N_CH(NCH), .WORD_W(WW), .ADDR_W(4), .AUTO_COMMIT(0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel),
        .omega(om[0]), .omega_update(upd[0]), .frame_err(err[0])
    );
    spi_omega_bank #(.N_CH(NCH), .WORD_W(WW), .ADDR_W(4), .AUTO_COMMIT(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel(ssel),
        .omega(om[1]), .omega_update(upd[1]), .frame_err(err[1])
    );

    task automatic chk(input bit ok, input string nm, input logic [OW-1:0] a, input logic [OW-1:0] e);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, a, e);
    endtask

    function automatic logic [OW-1:0] model_omega(input int m);
        logic [OW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*WW +: WW] = act[m][k];
        return v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NCH; k++) begin
                sh[m][k]  = '0;
                act[m][k] = '0;
            end
        end
    endtask

    task automatic push(input int m, input bit is_err, input int rise);
        exp_t e;
        e.is_err = is_err;
        e.omega  = model_omega(m);
        e.rise   = rise;
        sbq[m].push_back(e);
    endtask

    // Reference behaviour: judge the frame from its bit count and address.
    task automatic model_frame(input int nbits, input logic [63:0] bits, input int rise);
        logic [3:0]    addr;
        logic [WW-1:0] data;
        addr = bits[43:40];
        data = bits[39:0];
        if (nbits == 0) return;
        for (int m = 0; m < 2; m++) begin
            if (nbits != 44) begin
                push(m, 1'b1, rise);
            end else if (addr == 4'hF) begin
                for (int k = 0; k < NCH; k++) act[m][k] = sh[m][k];
                push(m, 1'b0, rise);
            end else if (int'(addr) < NCH) begin
                sh[m][addr[1:0]] = data;
                if (m == 1) begin
                    act[m][addr[1:0]] = data;
                    push(m, 1'b0, rise);
                end
            end else begin
                push(m, 1'b1, rise);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                prev_om[m] = om[m];
            end else begin
                if (upd[m] || err[m]) begin
                    n_pulse[m]++;
                    if (sbq[m].size() == 0) begin
                        chk(1'b0, $sformatf("unexpected_pulse_dut%0d", m),
                            OW'({upd[m], err[m]}), '0);
                    end else begin
                        exp_t e;
                        e = sbq[m].pop_front();
                        chk({upd[m], err[m]} == {~e.is_err, e.is_err},
                            $sformatf("pulse_kind_dut%0d", m),
                            OW'({upd[m], err[m]}), OW'({~e.is_err, e.is_err}));
                        chk(om[m] == e.omega, $sformatf("omega_dut%0d", m), om[m], e.omega);
                        chk(cyc - e.rise == LAT, $sformatf("latency_dut%0d", m),
                            OW'(cyc - e.rise), OW'(LAT));
                    end
                end else if (om[m] != prev_om[m]) begin
                    chk(1'b0, $sformatf("silent_omega_change_dut%0d", m), om[m], prev_om[m]);
                end
                prev_om[m] = om[m];
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int nbits, input logic [63:0] bits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = bits[i];
            clks(4);
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [63:0] bits, input int gap);
        ssel = 1'b0;
        clks(4);
        send_bits(nbits, bits);
        clks(4);
        ssel = 1'b1;
        model_frame(nbits, bits, cyc);
        clks(gap);
    endtask

    function automatic logic [63:0] wr(input logic [3:0] addr, input logic [WW-1:0] data);
        return {20'h0, addr, data};
    endfunction

    task automatic settle(input string tag);
        clks(12);
        for (int m = 0; m < 2; m++) begin
            chk(sbq[m].size() == 0, $sformatf("%s_drain_dut%0d", tag, m),
                OW'(sbq[m].size()), '0);
            chk(om[m] == model_omega(m), $sformatf("%s_omega_dut%0d", tag, m),
                om[m], model_omega(m));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int          r;
        int          p0 [2];

        model_reset();
        // Reset with random pins.
        rst_n = 1'b0;
        repeat (6) begin
            sck  = 1'($urandom);
            mosi = 1'($urandom);
            ssel = 1'($urandom);
            clks(1);
        end
        for (int m = 0; m < 2; m++) begin
            chk(om[m] == '0, $sformatf("reset_omega_dut%0d", m), om[m], '0);
            chk({upd[m], err[m]} == 2'b00, $sformatf("reset_pulses_dut%0d", m),
                OW'({upd[m], err[m]}), '0);
        end
        sck  = 1'b0;
        ssel = 1'b1;
        clks(1);
        rst_n = 1'b1;
        clks(20);
        for (int m = 0; m < 2; m++)
            chk(n_pulse[m] == 0, $sformatf("idle_no_pulse_dut%0d", m), OW'(n_pulse[m]), '0);

        // Shadow write then commit; auto-commit DUT updates immediately.
        send_frame(44, wr(4'd1, 40'h12_3456_789A), 6);
        settle("write_ch1");
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("commit1");
        send_frame(44, wr(4'd2, 40'hFF_FFFF_FFFF), 6);
        settle("write_ch2");

        // Wrong lengths and out-of-range address.
        v = {$urandom, $urandom};
        send_frame(43, v, 6);
        v = {$urandom, $urandom};
        send_frame(45, v, 6);
        send_frame(44, wr(4'd9, 40'hAB_CDEF_0123), 6);
        settle("bad_frames");
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("commit_after_bad");

        // Two shadows then one commit.
        send_frame(44, wr(4'd0, 40'h01_0203_0405), 6);
        send_frame(44, wr(4'd3, 40'hA5_5AA5_5AA5), 6);
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("commit_ch0_ch3");

        // Reset mid-frame; select left low across release must not start a frame.
        ssel = 1'b0;
        clks(4);
        v = {$urandom, $urandom};
        send_bits(20, v);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++)
            chk(om[m] == '0, $sformatf("midframe_reset_omega_dut%0d", m), om[m], '0);
        clks(3);
        rst_n = 1'b1;
        clks(4);
        send_bits(5, v);
        clks(4);
        ssel = 1'b1;
        clks(6);
        settle("after_reset");
        send_frame(44, wr(4'd2, 40'h55_6677_8899), 6);
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("frame_after_reset");

        // Select glitch without clocks, then back-to-back frames.
        for (int m = 0; m < 2; m++) p0[m] = n_pulse[m];
        ssel = 1'b0;
        clks(3);
        ssel = 1'b1;
        clks(12);
        for (int m = 0; m < 2; m++)
            chk(n_pulse[m] == p0[m], $sformatf("glitch_no_pulse_dut%0d", m),
                OW'(n_pulse[m] - p0[m]), '0);
        send_frame(44, wr(4'd1, 40'hC0_FFEE_0001), 1);
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("back_to_back");

        // Randomised frames.
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 9));
            v = {$urandom, $urandom};
            if (r <= 5)      send_frame(44, wr(4'($urandom_range(0, 3)), v[39:0]), 6);
            else if (r == 6) send_frame(44, wr(4'hF, v[39:0]), 6);
            else if (r == 7) send_frame(44, wr(4'($urandom_range(4, 14)), v[39:0]), 6);
            else if (r == 8) send_frame(($urandom_range(0, 1) == 0) ? 43 : 45, v, 6);
            else begin
                ssel = 1'b0;
                clks(int'($urandom_range(1, 5)));
                ssel = 1'b1;
                clks(8);
            end
        end
        send_frame(44, wr(4'hF, 40'h0), 6);
        settle("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
